// File: rtl/rh_issue_buf.sv
// ---------------------------------------------------------------------------
// rh_issue_buf
//   Receiving (issue) end of the fetch-to-issue channel. A DEPTH-entry FIFO
//   of {pc, instr} pairs with valid/ready handshakes on both sides, a
//   flush input that empties the buffer, and a RUN/HOLD state machine that
//   stalls issue without losing contents.
//
// Ports
//   clk      in   clock; all state updates on the rising edge
//   rstn     in   asynchronous active-low reset
//   f_vld    in   fetch side presents an instruction
//   f_rdy    out  buffer accepts the fetch beat (registered state and flush)
//   f_pc     in   PC of the presented instruction
//   f_instr  in   presented instruction word
//   i_vld    out  head entry valid for issue
//   i_rdy    in   issue consumer accepts the head entry
//   i_pc     out  PC of the head entry
//   i_instr  out  head instruction word
//   flush    in   discard all buffered instructions (redirect)
//   hold     in   stall issue; fetch pushes continue
//   count    out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module rh_issue_buf #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     f_vld,
    output logic                     f_rdy,
    input  logic [AW-1:0]            f_pc,
    input  logic [IW-1:0]            f_instr,
    output logic                     i_vld,
    input  logic                     i_rdy,
    output logic [AW-1:0]            i_pc,
    output logic [IW-1:0]            i_instr,
    input  logic                     flush,
    input  logic                     hold,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [CW-1:0]       cnt_q;
    logic                rdy_en_q;
    logic                push;
    logic                pop;

    logic [AW-1:0]       pc_mem    [DEPTH];
    logic [IW-1:0]       instr_mem [DEPTH];

    // rdy_en_q keeps f_rdy low while in reset and raises it on the first
    // clock after release, so f_rdy depends only on registered state plus
    // the flush qualifier and never on i_rdy.
    assign f_rdy = rdy_en_q && (cnt_q < CNT_FULL) && !flush;

    assign push  = f_vld && f_rdy;
    assign pop   = i_vld && i_rdy;

    assign count   = cnt_q;
    assign i_pc    = pc_mem[rd_ptr_q];
    assign i_instr = instr_mem[rd_ptr_q];

    // FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state (flush does not affect the state)
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (hold)  state_d = HOLD;
            HOLD:    if (!hold) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        i_vld = 1'b0;
        if ((cnt_q != '0) && (state_q == RUN) && !flush) begin
            i_vld = 1'b1;
        end
    end

    // Pointers and occupancy. Flush wins over any push/pop in the same cycle;
    // push and pop are already masked by flush through f_rdy and i_vld, the
    // explicit branch keeps that priority obvious.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + CW'(1);
                    2'b01:   cnt_q <= cnt_q - CW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= f_pc;
            instr_mem[wr_ptr_q] <= f_instr;
        end
    end

endmodule

// File: tb/tb_rh_issue_buf.sv
// ---------------------------------------------------------------------------
// tb_rh_issue_buf
//   Directed stimulus for rh_issue_buf with a scoreboard queue: accepted
//   fetch beats are queued, and a negedge monitor compares occupancy,
//   handshake outputs and the head entry against the queue every cycle.
// ---------------------------------------------------------------------------
module tb_rh_issue_buf;

    localparam int DEPTH = 4;
    localparam int IW    = 32;
    localparam int AW    = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic            f_vld;
    logic            f_rdy;
    logic [AW-1:0]   f_pc;
    logic [IW-1:0]   f_instr;
    logic            i_vld;
    logic            i_rdy;
    logic [AW-1:0]   i_pc;
    logic [IW-1:0]   i_instr;
    logic            flush;
    logic            hold;
    logic [2:0]      count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } ent_t;

    ent_t q[$];
    bit   m_hold = 1'b0;
    bit   m_rdy  = 1'b0;

    logic [AW-1:0] pc_n;
    bit            acc;

    rh_issue_buf #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .f_vld   (f_vld),
        .f_rdy   (f_rdy),
        .f_pc    (f_pc),
        .f_instr (f_instr),
        .i_vld   (i_vld),
        .i_rdy   (i_rdy),
        .i_pc    (i_pc),
        .i_instr (i_instr),
        .flush   (flush),
        .hold    (hold),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_instr(input logic [AW-1:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    // Advance one clock; the fetch PC moves on only when the beat was taken.
    task automatic step();
        #1;
        acc = f_vld && f_rdy && rstn;
        @(posedge clk);
        #1;
        if (acc) begin
            pc_n    = pc_n + 32'd4;
            f_pc    = pc_n;
            f_instr = mk_instr(pc_n);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        bit e_frdy;
        bit e_ivld;
        if (!rstn) begin
            q.delete();
            m_hold = 1'b0;
            m_rdy  = 1'b0;
        end else begin
            e_frdy = m_rdy && (q.size() < DEPTH) && !flush;
            e_ivld = (q.size() != 0) && !m_hold && !flush;
            chk("mon_count", 64'(count), 64'(q.size()));
            chk("mon_f_rdy", 64'(f_rdy), 64'(e_frdy));
            chk("mon_i_vld", 64'(i_vld), 64'(e_ivld));
            if (q.size() != 0) begin
                chk("mon_head_pc", 64'(i_pc), 64'(q[0].pc));
                chk("mon_head_instr", 64'(i_instr), 64'(q[0].instr));
            end
            if (flush) begin
                q.delete();
            end else begin
                if (e_ivld && i_rdy && q.size() != 0) void'(q.pop_front());
                if (e_frdy && f_vld) q.push_back('{f_pc, f_instr});
            end
            m_hold = hold;
            m_rdy  = 1'b1;
        end
    end

    initial begin
        logic [AW-1:0] p0;

        rstn  = 1'b0;
        f_vld = 1'b0;
        i_rdy = 1'b0;
        flush = 1'b0;
        hold  = 1'b0;
        pc_n  = 32'h100;
        f_pc  = pc_n;
        f_instr = mk_instr(pc_n);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_i_vld", 64'(i_vld), 64'd0);
        chk("rst_f_rdy", 64'(f_rdy), 64'd0);
        rstn = 1'b1;
        #1 chk("rel_f_rdy_before_edge", 64'(f_rdy), 64'd0);
        step();
        #1 chk("rel_f_rdy_after_edge", 64'(f_rdy), 64'd1);

        // Fill four beats with issue stalled, then drain in order
        f_vld = 1'b1;
        repeat (4) step();
        f_vld = 1'b0;
        #1;
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_f_rdy", 64'(f_rdy), 64'd0);
        chk("fill_i_vld", 64'(i_vld), 64'd1);
        i_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("drain_pc", 64'(i_pc), 64'(32'h100 + 32'(4 * k)));
            step();
        end
        i_rdy = 1'b0;
        #1;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_i_vld", 64'(i_vld), 64'd0);

        // Full buffer with both sides active: first cycle pop only, then
        // one push and one pop per cycle
        f_vld = 1'b1;
        repeat (4) step();
        i_rdy = 1'b1;
        #1;
        chk("full_both_count", 64'(count), 64'd4);
        chk("full_both_f_rdy", 64'(f_rdy), 64'd0);
        step();
        #1;
        chk("after_full_count", 64'(count), 64'd3);
        chk("after_full_f_rdy", 64'(f_rdy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            #1 chk("stream_count", 64'(count), 64'd3);
        end
        f_vld = 1'b0;
        repeat (4) step();
        i_rdy = 1'b0;
        #1 chk("stream_drain_count", 64'(count), 64'd0);

        // Flush at count 3 with a beat presented
        f_vld = 1'b1;
        repeat (3) step();
        flush = 1'b1;
        #1;
        chk("flush_i_vld", 64'(i_vld), 64'd0);
        chk("flush_f_rdy", 64'(f_rdy), 64'd0);
        chk("flush_count_before", 64'(count), 64'd3);
        p0 = pc_n;
        step();
        flush = 1'b0;
        f_vld = 1'b0;
        #1;
        chk("flush_count_after", 64'(count), 64'd0);
        chk("flush_i_vld_after", 64'(i_vld), 64'd0);
        f_vld = 1'b1;
        step();
        f_vld = 1'b0;
        #1;
        chk("post_flush_count", 64'(count), 64'd1);
        chk("post_flush_head", 64'(i_pc), 64'(p0));
        i_rdy = 1'b1;
        step();
        i_rdy = 1'b0;
        #1 chk("post_flush_empty", 64'(count), 64'd0);

        // Hold with two entries, pushes continue, original head issues first
        p0 = pc_n;
        f_vld = 1'b1;
        repeat (2) step();
        hold = 1'b1;
        step();
        i_rdy = 1'b1;
        #1;
        chk("hold_i_vld", 64'(i_vld), 64'd0);
        chk("hold_count3", 64'(count), 64'd3);
        step();
        f_vld = 1'b0;
        #1;
        chk("hold_count4", 64'(count), 64'd4);
        chk("hold_i_vld_full", 64'(i_vld), 64'd0);
        step();
        hold = 1'b0;
        #1 chk("unhold_same_cycle_i_vld", 64'(i_vld), 64'd0);
        step();
        #1;
        chk("unhold_i_vld", 64'(i_vld), 64'd1);
        chk("unhold_head_pc", 64'(i_pc), 64'(p0));
        repeat (4) step();
        i_rdy = 1'b0;
        #1 chk("unhold_drain_count", 64'(count), 64'd0);

        // Random traffic against the scoreboard
        for (int k = 0; k < 2000; k++) begin
            f_vld = 1'($urandom_range(0, 1));
            i_rdy = 1'($urandom_range(0, 1));
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 63) == 0);
            step();
        end
        f_vld = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        i_rdy = 1'b1;
        repeat (8) step();
        i_rdy = 1'b0;
        #1 chk("rand_drain_count", 64'(count), 64'd0);

        // Asynchronous reset with two entries buffered
        f_vld = 1'b1;
        repeat (2) step();
        f_vld = 1'b0;
        #1;
        chk("pre_async_count", 64'(count), 64'd2);
        chk("pre_async_i_vld", 64'(i_vld), 64'd1);
        #1 rstn = 1'b0;
        #1;
        chk("async_i_vld", 64'(i_vld), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        chk("async_f_rdy", 64'(f_rdy), 64'd0);
        step();
        step();
        rstn = 1'b1;
        #1 chk("async_rel_f_rdy_before", 64'(f_rdy), 64'd0);
        step();
        #1;
        chk("async_rel_f_rdy_after", 64'(f_rdy), 64'd1);
        chk("async_rel_count", 64'(count), 64'd0);
        p0 = pc_n;
        f_vld = 1'b1;
        step();
        f_vld = 1'b0;
        #1;
        chk("after_rst_count", 64'(count), 64'd1);
        chk("after_rst_head", 64'(i_pc), 64'(p0));
        i_rdy = 1'b1;
        step();
        i_rdy = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
